// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: BCD hh:mm:ss time-of-day counter with an internal one-second
// prescaler, 24h or 12h (AM/PM) mode, a validated synchronous load and a
// one-shot hh:mm alarm. All outputs are registered for the display path.
module bcd_timekeeper #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter bit MODE_12H      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        load_valid,
  input  logic [23:0] load_time,
  input  logic        load_pm,
  output logic        load_err,
  input  logic        alarm_wr,
  input  logic [15:0] alarm_time,
  input  logic        alarm_pm,
  output logic        alarm_hit,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        sec_pulse
);

  localparam int              PW        = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [23:0]     TIME_RST  = MODE_12H ? 24'h120000 : 24'h000000;

  logic [PW-1:0] presc;
  logic [23:0]   time_q;
  logic          pm_q;
  logic [15:0]   alarm_q;
  logic          alarm_pm_q;
  logic          armed;

  logic          tc;
  logic          load_ok;
  logic          advance;
  logic          match;
  logic [23:0]   time_nxt;
  logic          pm_nxt;

  // A load is accepted only if every digit is in range for the current mode.
  function automatic logic load_is_valid(input logic [23:0] t);
    logic ok;
    ok = (t[19:16] <= 4'd9) && (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
         (t[7:4]   <= 4'd5) && (t[3:0]   <= 4'd9);
    if (MODE_12H)
      ok = ok && (((t[23:20] == 4'd0) && (t[19:16] != 4'd0)) ||
                  ((t[23:20] == 4'd1) && (t[19:16] <= 4'd2)));
    else
      ok = ok && ((t[23:20] <= 4'd1) ||
                  ((t[23:20] == 4'd2) && (t[19:16] <= 4'd3)));
    return ok;
  endfunction

  assign tc      = run && (presc == PRESC_MAX);
  assign load_ok = load_valid && load_is_valid(load_time);
  // A valid load wins over a coincident advance; a rejected load does not block it.
  assign advance = tc && !load_ok;

  // Full carry chain: one combined next-state for a single one-second advance.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    time_nxt = time_q;
    pm_nxt   = pm_q;
    if (time_q[3:0] != 4'd9) begin
      time_nxt[3:0] = time_q[3:0] + 4'd1;
    end else begin
      time_nxt[3:0] = 4'd0;
      if (time_q[7:4] != 4'd5) begin
        time_nxt[7:4] = time_q[7:4] + 4'd1;
      end else begin
        time_nxt[7:4] = 4'd0;
        if (time_q[11:8] != 4'd9) begin
          time_nxt[11:8] = time_q[11:8] + 4'd1;
        end else begin
          time_nxt[11:8] = 4'd0;
          if (time_q[15:12] != 4'd5) begin
            time_nxt[15:12] = time_q[15:12] + 4'd1;
          end else begin
            time_nxt[15:12] = 4'd0;
            if (MODE_12H && (time_q[23:16] == 8'h12)) begin
              time_nxt[23:16] = 8'h01;
            end else if (MODE_12H && (time_q[23:16] == 8'h11)) begin
              time_nxt[23:16] = 8'h12;
              pm_nxt          = ~pm_q;
            end else if (!MODE_12H && (time_q[23:16] == 8'h23)) begin
              time_nxt[23:16] = 8'h00;
            end else if (time_q[19:16] == 4'd9) begin
              time_nxt[23:16] = {time_q[23:20] + 4'd1, 4'd0};
            end else begin
              time_nxt[19:16] = time_q[19:16] + 4'd1;
            end
          end
        end
      end
    end
  end

  // Alarm fires only on an advance landing on hh:mm:00; a same-cycle re-arm suppresses it.
  assign match = advance && armed && !alarm_wr &&
                 (time_nxt[7:0] == 8'h00) && (time_nxt[23:8] == alarm_q) &&
                 (!MODE_12H || (pm_nxt == alarm_pm_q));

  // Prescaler: cleared by a valid load, frozen while run is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (load_ok) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      presc <= '0;
    end else if (run) begin
      presc <= tc ? '0 : presc + 1'b1;
    end
  end

  // Time and pm registers: load has priority over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q <= TIME_RST;
      pm_q   <= 1'b0;
    end else if (load_ok) begin
      time_q <= load_time;
      pm_q   <= MODE_12H ? load_pm : 1'b0;
    end else if (advance) begin
      time_q <= time_nxt;
      pm_q   <= pm_nxt;
    end
  end

  // Stored alarm and one-shot armed flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q    <= '0;
      alarm_pm_q <= 1'b0;
      armed      <= 1'b0;
    end else if (alarm_wr) begin
      alarm_q    <= alarm_time;
      alarm_pm_q <= alarm_pm;
      armed      <= 1'b1;
    end else if (match) begin
      armed      <= 1'b0;
    end
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_pulse <= 1'b0;
      load_err  <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      sec_pulse <= advance;
      load_err  <= load_valid && !load_ok;
      alarm_hit <= match;
    end
  end

  assign time_bcd = time_q;
  assign pm       = MODE_12H ? pm_q : 1'b0;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed testbench for bcd_timekeeper: one 24h and one 12h instance,
// both with TICKS_PER_SEC=4, expected values computed by hand.
module tb_bcd_timekeeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;

  logic        load_valid24, load_valid12;
  logic [23:0] load_time24,  load_time12;
  logic        load_pm12;
  logic        alarm_wr;
  logic [15:0] alarm_time;

  logic        load_err24, load_err12;
  logic        alarm_hit24, alarm_hit12;
  logic [23:0] time24, time12;
  logic        pm24, pm12;
  logic        sec_pulse24, sec_pulse12;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_timekeeper #(.TICKS_PER_SEC(4), .MODE_12H(1'b0)) dut24 (
    .clk(clk), .rst_n(rst_n), .run(run),
    .load_valid(load_valid24), .load_time(load_time24), .load_pm(1'b0),
    .load_err(load_err24),
    .alarm_wr(alarm_wr), .alarm_time(alarm_time), .alarm_pm(1'b0),
    .alarm_hit(alarm_hit24),
    .time_bcd(time24), .pm(pm24), .sec_pulse(sec_pulse24)
  );

  bcd_timekeeper #(.TICKS_PER_SEC(4), .MODE_12H(1'b1)) dut12 (
    .clk(clk), .rst_n(rst_n), .run(run),
    .load_valid(load_valid12), .load_time(load_time12), .load_pm(load_pm12),
    .load_err(load_err12),
    .alarm_wr(1'b0), .alarm_time(16'h0000), .alarm_pm(1'b0),
    .alarm_hit(alarm_hit12),
    .time_bcd(time12), .pm(pm12), .sec_pulse(sec_pulse12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next sec_pulse, then check its latency and the new time.
  task automatic adv(input string tag, input bit sel12, input int exp_n,
                     input logic [23:0] exp_t);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = sel12 ? sec_pulse12 : sec_pulse24;
    end
    check({tag, "_cyc"}, 32'(n), 32'(exp_n));
    check({tag, "_t"}, 32'(sel12 ? time12 : time24), 32'(exp_t));
  endtask

  task automatic load24(input logic [23:0] t);
    load_valid24 = 1'b1;
    load_time24  = t;
    tick();
    load_valid24 = 1'b0;
  endtask

  task automatic load12(input logic [23:0] t, input logic p);
    load_valid12 = 1'b1;
    load_time12  = t;
    load_pm12    = p;
    tick();
    load_valid12 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;  run = 1'b0;
    load_valid24 = 1'b0; load_time24 = '0;
    load_valid12 = 1'b0; load_time12 = '0; load_pm12 = 1'b0;
    alarm_wr = 1'b0; alarm_time = '0;
    repeat (3) tick();

    // Reset state
    check("rst_time24", 32'(time24), 32'h000000);
    check("rst_pulse24", 32'(sec_pulse24), 32'd0);
    check("rst_err24", 32'(load_err24), 32'd0);
    check("rst_hit24", 32'(alarm_hit24), 32'd0);
    check("rst_time12", 32'(time12), 32'h120000);
    check("rst_pm12", 32'(pm12), 32'd0);

    // Free run: pulse every 4th cycle, 60 pulses -> 00:01:00
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 1; k <= 240; k++) begin
      tick();
      check("pulse_cadence", 32'(sec_pulse24), 32'(k % 4 == 0));
      if (k == 4) check("first_sec", 32'(time24), 32'h000001);
    end
    check("one_minute", 32'(time24), 32'h000100);

    // Load and full 24h rollover
    load24(24'h235958);
    check("load_t", 32'(time24), 32'h235958);
    check("load_nopulse", 32'(sec_pulse24), 32'd0);
    check("load_noerr", 32'(load_err24), 32'd0);
    adv("roll_a", 1'b0, 4, 24'h235959);
    adv("roll_b", 1'b0, 4, 24'h000000);

    // Invalid load (min_msb=6): rejected, prescaler keeps its phase
    load24(24'h096959);
    check("bad_err", 32'(load_err24), 32'd1);
    check("bad_keep", 32'(time24), 32'h000000);
    tick();
    check("bad_err_once", 32'(load_err24), 32'd0);
    adv("bad_phase", 1'b0, 2, 24'h000001);
    load24(24'h240000);
    check("bad_hr24", 32'(load_err24), 32'd1);

    // 12h mode
    load12(24'h115959, 1'b0);
    check("h12_load", 32'(time12), 32'h115959);
    adv("h12_noon", 1'b1, 4, 24'h120000);
    check("h12_noon_pm", 32'(pm12), 32'd1);
    load12(24'h125959, 1'b1);
    adv("h12_one", 1'b1, 4, 24'h010000);
    check("h12_one_pm", 32'(pm12), 32'd1);
    load12(24'h115959, 1'b1);
    adv("h12_mid", 1'b1, 4, 24'h120000);
    check("h12_mid_pm", 32'(pm12), 32'd0);
    load12(24'h000000, 1'b0);
    check("h12_bad_err", 32'(load_err12), 32'd1);
    check("h12_bad_keep", 32'(time12), 32'h120000);
    load12(24'h130000, 1'b0);
    check("h12_bad13", 32'(load_err12), 32'd1);
    check("pm24_zero", 32'(pm24), 32'd0);

    // Alarm: arm 07:01 and load 07:00:58 in the same cycle
    alarm_wr = 1'b1; alarm_time = 16'h0701;
    load24(24'h070058);
    alarm_wr = 1'b0;
    adv("al_a", 1'b0, 4, 24'h070059);
    check("al_a_hit", 32'(alarm_hit24), 32'd0);
    adv("al_b", 1'b0, 4, 24'h070100);
    check("al_b_hit", 32'(alarm_hit24), 32'd1);
    tick();
    check("al_b_once", 32'(alarm_hit24), 32'd0);
    // One-shot: same time again, no second hit
    load24(24'h070058);
    adv("al_c", 1'b0, 4, 24'h070059);
    adv("al_d", 1'b0, 4, 24'h070100);
    check("al_d_hit", 32'(alarm_hit24), 32'd0);
    // Re-arm, then a load landing on 07:01:00 must not fire
    alarm_wr = 1'b1; tick(); alarm_wr = 1'b0;
    load24(24'h070100);
    check("al_load_hit", 32'(alarm_hit24), 32'd0);
    adv("al_e", 1'b0, 4, 24'h070101);
    check("al_e_hit", 32'(alarm_hit24), 32'd0);
    // alarm_wr coincident with matching advance: stored, no hit, stays armed
    load24(24'h070059);
    repeat (3) tick();
    alarm_wr = 1'b1;
    tick();
    alarm_wr = 1'b0;
    check("al_wr_pulse", 32'(sec_pulse24), 32'd1);
    check("al_wr_t", 32'(time24), 32'h070100);
    check("al_wr_hit", 32'(alarm_hit24), 32'd0);
    load24(24'h070059);
    adv("al_f", 1'b0, 4, 24'h070100);
    check("al_f_hit", 32'(alarm_hit24), 32'd1);

    // Valid load on the terminal-count cycle
    repeat (3) tick();
    load24(24'h123455);
    check("tc_load_t", 32'(time24), 32'h123455);
    check("tc_load_pulse", 32'(sec_pulse24), 32'd0);
    adv("tc_next", 1'b0, 4, 24'h123456);

    // run=0 freezes time and prescaler
    repeat (2) tick();
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("frz_pulse", 32'(sec_pulse24), 32'd0);
    end
    check("frz_t", 32'(time24), 32'h123456);
    run = 1'b1;
    adv("frz_resume", 1'b0, 2, 24'h123457);

    // Asynchronous reset mid-count at 12:34:56
    load24(24'h123456);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_t24", 32'(time24), 32'h000000);
    check("arst_pulse", 32'(sec_pulse24), 32'd0);
    check("arst_t12", 32'(time12), 32'h120000);
    check("arst_pm12", 32'(pm12), 32'd0);
    tick();
    rst_n = 1'b1;
    adv("arst_restart", 1'b0, 4, 24'h000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
